// File: rtl/cdi_periph_pkg.sv
// Shared definitions for the CD-i serial pointing device: FSM states, ID/header bits,
// and the 3-byte report packing.
package cdi_periph_pkg;

    typedef enum logic [2:0] {
        OFF,
        ID_WAIT,
        IDLE,
        SEND,
        GAP
    } pd_state_e;

    localparam logic [7:0] PD_ID_BYTE  = 8'h4D;
    localparam logic [1:0] PD_HDR_BITS = 2'b11;
    localparam logic [1:0] PD_PAD_BITS = 2'b00;

    typedef struct packed {
        logic [1:0] btn;
        logic [7:0] x;
        logic [7:0] y;
    } pd_report_t;

    // Byte idx of a report: header with buttons and motion MSBs, then X and Y low bits
    function automatic logic [7:0] pd_packet_byte(input pd_report_t r, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {PD_HDR_BITS, r.btn[0], r.btn[1], r.y[7:6], r.x[7:6]};
            2'd1:    b = {PD_PAD_BITS, r.x[5:0]};
            default: b = {PD_PAD_BITS, r.y[5:0]};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bytestream.sv
// Unbuffered byte stream: data qualified by a single-cycle strobe, no back-pressure.
interface bytestream;
    logic [7:0] data;
    logic       strobe;

    modport source (output data, strobe);
    modport sink   (input  data, strobe);
endinterface

// File: rtl/sat_accum8.sv
// 8-bit signed accumulator with saturation; clear and add in the same cycle yields sat(0+delta).
module sat_accum8 (
    input  logic       clk30,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] delta,
    output logic [7:0] acc
);

    logic [7:0]        base_c;
    logic signed [8:0] sum_c;
    logic [7:0]        acc_d;

    always_comb begin
        base_c = clear ? 8'h00 : acc;
        sum_c  = $signed({base_c[7], base_c}) + $signed({delta[7], delta});
        acc_d  = base_c;
        if (add) begin
            if (sum_c > 9'sd127) begin
                acc_d = 8'h7F;
            end else if (sum_c < -9'sd128) begin
                acc_d = 8'h80;
            end else begin
                acc_d = sum_c[7:0];
            end
        end
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            acc <= 8'h00;
        end else begin
            acc <= acc_d;
        end
    end

endmodule

// File: rtl/pointing_device_serial.sv
// Serial mouse emulation: sends 0x4D on power-up (rts rise), then 3-byte reports of
// accumulated joystick motion and button changes, one byte per BYTE_GAP+1 cycles.
module pointing_device_serial
    import cdi_periph_pkg::*;
#(
    parameter int unsigned BYTE_GAP = 225000,
    parameter int unsigned ID_DELAY = 300000
) (
    input  logic       clk30,
    input  logic       reset,
    input  logic       rts,
    input  logic [7:0] joy_dx,
    input  logic [7:0] joy_dy,
    input  logic       joy_valid,
    input  logic [1:0] btn,
    bytestream.source  serial_out
);

    localparam int unsigned CNT_MAX = (BYTE_GAP > ID_DELAY) ? BYTE_GAP : ID_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    pd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             id_gap_q, id_gap_d;
    logic             rts_q;
    pd_report_t       tx_q, tx_d;
    logic [1:0]       btn_sent_q, btn_sent_d;
    logic             strobe_q, strobe_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       acc_x, acc_y;
    logic             acc_clear_c, acc_add_c, pending_c;

    assign pending_c = (acc_x != 8'h00) || (acc_y != 8'h00) || (btn != btn_sent_q);

    sat_accum8 u_acc_x (
        .clk30 (clk30),
        .reset (reset),
        .clear (acc_clear_c),
        .add   (acc_add_c),
        .delta (joy_dx),
        .acc   (acc_x)
    );

    sat_accum8 u_acc_y (
        .clk30 (clk30),
        .reset (reset),
        .clear (acc_clear_c),
        .add   (acc_add_c),
        .delta (joy_dy),
        .acc   (acc_y)
    );

    // Next-state and output decode; a dropped rts overrides every state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        id_gap_d    = id_gap_q;
        tx_d        = tx_q;
        btn_sent_d  = btn_sent_q;
        strobe_d    = 1'b0;
        data_d      = data_q;
        acc_clear_c = 1'b0;
        acc_add_c   = joy_valid;

        if (!rts) begin
            state_d     = OFF;
            cnt_d       = '0;
            idx_d       = 2'd0;
            id_gap_d    = 1'b0;
            acc_clear_c = 1'b1;
            acc_add_c   = 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    acc_clear_c = 1'b1;
                    acc_add_c   = 1'b0;
                    if (!rts_q) begin
                        state_d = ID_WAIT;
                        cnt_d   = '0;
                    end
                end
                ID_WAIT: begin
                    if (cnt_q == CNT_W'(ID_DELAY - 1)) begin
                        state_d  = GAP;
                        cnt_d    = '0;
                        id_gap_d = 1'b1;
                        strobe_d = 1'b1;
                        data_d   = PD_ID_BYTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (pending_c) begin
                        tx_d        = '{btn: btn, x: acc_x, y: acc_y};
                        btn_sent_d  = btn;
                        idx_d       = 2'd0;
                        state_d     = SEND;
                        strobe_d    = 1'b1;
                        data_d      = pd_packet_byte(tx_d, 2'd0);
                        acc_clear_c = 1'b1;
                    end
                end
                SEND: begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
                GAP: begin
                    if (cnt_q == CNT_W'(BYTE_GAP - 1)) begin
                        cnt_d = '0;
                        if (id_gap_q || (idx_q == 2'd2)) begin
                            state_d  = IDLE;
                            idx_d    = 2'd0;
                            id_gap_d = 1'b0;
                        end else begin
                            state_d  = SEND;
                            idx_d    = idx_q + 2'd1;
                            strobe_d = 1'b1;
                            data_d   = pd_packet_byte(tx_q, idx_q + 2'd1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk30) begin
        if (reset) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            id_gap_q   <= 1'b0;
            rts_q      <= 1'b0;
            tx_q       <= '0;
            btn_sent_q <= 2'b00;
            strobe_q   <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            id_gap_q   <= id_gap_d;
            rts_q      <= rts;
            tx_q       <= tx_d;
            btn_sent_q <= btn_sent_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
        end
    end

    assign serial_out.data   = data_q;
    assign serial_out.strobe = strobe_q;

endmodule

// File: tb/tb_pointing_device_serial.sv
// Bench for pointing_device_serial: directed scenarios plus randomized motion/buttons
// checked against a queue-based report model.
module tb_pointing_device_serial;

    localparam int BG  = 20;
    localparam int IDD = 30;

    logic       clk30 = 1'b0;
    logic       reset;
    logic       rts;
    logic [7:0] joy_dx;
    logic [7:0] joy_dy;
    logic       joy_valid;
    logic [1:0] btn;

    bytestream so_if ();

    pointing_device_serial #(.BYTE_GAP(BG), .ID_DELAY(IDD)) dut (
        .clk30      (clk30),
        .reset      (reset),
        .rts        (rts),
        .joy_dx     (joy_dx),
        .joy_dy     (joy_dy),
        .joy_valid  (joy_valid),
        .btn        (btn),
        .serial_out (so_if)
    );

    always #5 clk30 = ~clk30;

    typedef struct {
        logic [7:0] d;
        int         t;
    } obs_t;

    obs_t       obs_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         last_t = 0;
    logic [7:0] last_d = 8'h00;
    int         m_x, m_y;
    logic [1:0] m_btn_sent;

    always @(posedge clk30) cyc <= cyc + 1;

    // Record every strobed byte with the cycle it appeared in
    always @(posedge clk30) begin
        #1;
        if (so_if.strobe === 1'b1) obs_q.push_back('{d: so_if.data, t: cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [7:0] rpt_byte(input logic [1:0] b, input int x, input int y,
                                            input int k);
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        if (k == 0) return {2'b11, b[0], b[1], yb[7:6], xb[7:6]};
        if (k == 1) return {2'b00, xb[5:0]};
        return {2'b00, yb[5:0]};
    endfunction

    function automatic bit model_pending();
        return (m_x != 0) || (m_y != 0) || (btn != m_btn_sent);
    endfunction

    task automatic model_snap(output logic [7:0] e0, output logic [7:0] e1,
                              output logic [7:0] e2);
        e0 = rpt_byte(btn, m_x, m_y, 0);
        e1 = rpt_byte(btn, m_x, m_y, 1);
        e2 = rpt_byte(btn, m_x, m_y, 2);
        m_x = 0;
        m_y = 0;
        m_btn_sent = btn;
    endtask

    task automatic pulse(input logic [7:0] dx, input logic [7:0] dy);
        joy_dx    = dx;
        joy_dy    = dy;
        joy_valid = 1'b1;
        if (rts) begin
            m_x = sat8(m_x + int'($signed(dx)));
            m_y = sat8(m_y + int'($signed(dy)));
        end
        @(negedge clk30);
        joy_valid = 1'b0;
    endtask

    task automatic wait_strobe(output logic [7:0] d, output int t, input int budget);
        obs_t e;
        int n = 0;
        while (obs_q.size() == 0 && n < budget) begin
            @(negedge clk30);
            n++;
        end
        if (obs_q.size() == 0) begin
            check("strobe_timeout", obs_q.size(), 1);
            d = 8'h00;
            t = 0;
        end else begin
            e = obs_q.pop_front();
            d = e.d;
            t = e.t;
            last_d = e.d;
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        repeat (n) @(negedge clk30);
        check(tag, obs_q.size(), 0);
        check({tag, "_hold"}, so_if.data, last_d);
        obs_q.delete();
    endtask

    // mode 0: none, 1: three +100 X pulses, 2: random motion and button changes
    task automatic inject(input int mode);
        if (mode == 1) begin
            repeat (3) begin
                pulse(8'd100, 8'd0);
                @(negedge clk30);
            end
        end else if (mode == 2) begin
            int n;
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk30);
                if ($urandom_range(0, 3) == 0) btn = 2'($urandom);
                pulse(8'($urandom), 8'($urandom));
            end
        end
    endtask

    task automatic recv_packet(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input int t_first, input int mode);
        logic [7:0] d;
        int t, t_prev;
        wait_strobe(d, t, t_first - cyc + 4);
        check({tag, "_b0"}, d, e0);
        check({tag, "_b0_time"}, t, t_first);
        t_prev = t;
        for (int k = 1; k < 3; k++) begin
            inject(mode);
            wait_strobe(d, t, BG + 4);
            check($sformatf("%s_b%0d", tag, k), d, (k == 1) ? e1 : e2);
            check($sformatf("%s_b%0d_gap", tag, k), t - t_prev, BG + 1);
            t_prev = t;
        end
        last_t = t_prev;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: no completion by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e0, e1, e2, d;
        int t, n0;

        reset = 1'b1; rts = 1'b1; btn = 2'b00;
        joy_valid = 1'b0; joy_dx = 8'h00; joy_dy = 8'h00;
        m_x = 0; m_y = 0; m_btn_sent = 2'b00;

        repeat (3) @(negedge clk30);
        check("rst_strobe", so_if.strobe, 0);
        check("rst_data", so_if.data, 0);

        // rts already high through reset still yields an ID byte
        n0 = cyc; reset = 1'b0;
        wait_strobe(d, t, IDD + 6);
        check("id_rst_data", d, 8'h4D);
        check("id_rst_time", t - n0, IDD + 1);
        expect_quiet("id_rst_quiet", BG + 4);

        rts = 1'b0;
        repeat (3) @(negedge clk30);
        n0 = cyc; rts = 1'b1;
        wait_strobe(d, t, IDD + 6);
        check("id_data", d, 8'h4D);
        check("id_time", t - n0, IDD + 1);
        expect_quiet("id_quiet", BG + 4);

        n0 = cyc;
        pulse(8'd5, 8'hFD);
        model_snap(e0, e1, e2);
        recv_packet("move", 8'hCC, 8'h05, 8'h3D, n0 + 2, 1);

        model_snap(e0, e1, e2);
        recv_packet("sat", 8'hC1, 8'h3F, 8'h00, last_t + BG + 2, 0);
        expect_quiet("sat_quiet", BG + 4);

        n0 = cyc; btn = 2'b01;
        model_snap(e0, e1, e2);
        recv_packet("btn", 8'hE0, 8'h00, 8'h00, n0 + 1, 0);
        expect_quiet("btn_held", 2 * BG + 4);

        // motion arriving on the snapshot cycle belongs to the following report
        n0 = cyc; btn = 2'b00;
        model_snap(e0, e1, e2);
        pulse(8'd7, 8'd0);
        recv_packet("snap", 8'hC0, 8'h00, 8'h00, n0 + 1, 0);
        model_snap(e0, e1, e2);
        recv_packet("snap_next", 8'hC0, 8'h07, 8'h00, last_t + BG + 2, 0);
        expect_quiet("snap_quiet", BG + 4);

        n0 = cyc;
        pulse(8'd3, 8'd0);
        model_snap(e0, e1, e2);
        wait_strobe(d, t, 8);
        check("abort_b0", d, 8'hC0);
        check("abort_b0_time", t, n0 + 2);
        rts = 1'b0;
        pulse(8'd9, 8'd9);
        expect_quiet("abort_quiet", 2 * BG + 4);
        m_x = 0; m_y = 0;
        n0 = cyc; rts = 1'b1;
        wait_strobe(d, t, IDD + 6);
        check("rearm_id", d, 8'h4D);
        check("rearm_time", t - n0, IDD + 1);
        expect_quiet("rearm_quiet", BG + 4);

        for (int r = 0; r < 8; r++) begin
            logic [7:0] dx, dy;
            int np;
            dx = 8'($urandom);
            dy = 8'($urandom);
            if (dx == 8'h00 && dy == 8'h00) dx = 8'h01;
            n0 = cyc;
            pulse(dx, dy);
            model_snap(e0, e1, e2);
            recv_packet("rnd", e0, e1, e2, n0 + 2, 2);
            np = 0;
            while (model_pending() && np < 4) begin
                model_snap(e0, e1, e2);
                recv_packet("rnd_next", e0, e1, e2, last_t + BG + 2, (np < 2) ? 2 : 0);
                np++;
            end
            expect_quiet("rnd_quiet", BG + 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
